// File: rtl/lcd_clk_pkg.sv
// Shared types and defaults for the LCD pixel-clock divider sequencing logic.
package lcd_clk_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2,
    CALIB     = 2'd3
  } lcd_state_e;

  localparam int unsigned LOCK_CYCLES_DEF   = 1024;
  localparam int unsigned SETTLE_CYCLES_DEF = 64;
  localparam int unsigned CALIB_HIGH_DEF    = 4;
  localparam int unsigned CALIB_GAP_DEF     = 8;

  // One shared counter serves every timed phase, so it is sized for the longest.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/lcd_sync2.sv
// Two-flop synchroniser for a single asynchronous level; clears to 0 on reset.
module lcd_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) sync_q <= 2'b00;
    else       sync_q <= {sync_q[0], d_i};
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/lcd_clkdiv_ctrl.sv
// Power-up and phase-trim sequencer for the LCD pixel-clock divider: lock qualify,
// divider reset release, settle, LCD reset release, then counted CALIB pulse trains.
module lcd_clkdiv_ctrl
  import lcd_clk_pkg::*;
#(
  parameter int unsigned LOCK_CYCLES   = LOCK_CYCLES_DEF,
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int unsigned CALIB_HIGH    = CALIB_HIGH_DEF,
  parameter int unsigned CALIB_GAP     = CALIB_GAP_DEF,
  parameter int unsigned STEP_W        = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pll_lock,
  input  logic              calib_req,
  input  logic [STEP_W-1:0] calib_steps,
  output logic              div_resetn,
  output logic              div_calib,
  output logic              lcd_rst,
  output logic              ready,
  output logic              busy,
  output logic              calib_done,
  output lcd_state_e        dbg_state
);

  localparam int unsigned CNT_W = cnt_width(LOCK_CYCLES, SETTLE_CYCLES, CALIB_HIGH, CALIB_GAP);
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0]  LOCK_LAST   = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  HIGH_LAST   = CNT_W'(CALIB_HIGH - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST    = CNT_W'(CALIB_GAP - 1);
  localparam logic [STEP_W-1:0] STEP_ONE    = STEP_W'(1);

  logic lk;

  lcd_sync2 u_lock_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (pll_lock),
    .q_o   (lk)
  );

  lcd_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic div_resetn_q, div_resetn_d;
  logic div_calib_q, div_calib_d;
  logic lcd_rst_q, lcd_rst_d;
  logic ready_q, ready_d;
  logic busy_q, busy_d;
  logic calib_done_q, calib_done_d;

  // Handshake: calib_req is a one-cycle strobe taken only while ready is high;
  // there is no backpressure, and a strobe seen while not ready is dropped.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    steps_d      = steps_q;
    div_resetn_d = div_resetn_q;
    div_calib_d  = div_calib_q;
    lcd_rst_d    = lcd_rst_q;
    ready_d      = ready_q;
    busy_d       = busy_q;
    calib_done_d = 1'b0;

    if (state_q != WAIT_LOCK && !lk) begin
      state_d      = WAIT_LOCK;
      cnt_d        = '0;
      steps_d      = '0;
      div_resetn_d = 1'b0;
      div_calib_d  = 1'b0;
      lcd_rst_d    = 1'b1;
      ready_d      = 1'b0;
      busy_d       = 1'b0;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          if (!lk) begin
            cnt_d = '0;
          end else if (cnt_q == LOCK_LAST) begin
            state_d      = SETTLE;
            cnt_d        = '0;
            div_resetn_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            state_d   = RUN;
            cnt_d     = '0;
            lcd_rst_d = 1'b0;
            ready_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        RUN: begin
          if (calib_req) begin
            steps_d = calib_steps;
            if (calib_steps == '0) begin
              calib_done_d = 1'b1;
            end else begin
              state_d     = CALIB;
              cnt_d       = '0;
              busy_d      = 1'b1;
              ready_d     = 1'b0;
              div_calib_d = 1'b1;
            end
          end
        end
        CALIB: begin
          // The registered div_calib level doubles as the high/gap phase flag.
          if (div_calib_q) begin
            if (cnt_q == HIGH_LAST) begin
              cnt_d       = '0;
              div_calib_d = 1'b0;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else if (cnt_q == GAP_LAST) begin
            cnt_d = '0;
            if (steps_q == STEP_ONE) begin
              state_d      = RUN;
              steps_d      = '0;
              busy_d       = 1'b0;
              ready_d      = 1'b1;
              calib_done_d = 1'b1;
            end else begin
              steps_d     = steps_q - STEP_ONE;
              div_calib_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: state_d = WAIT_LOCK;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= WAIT_LOCK;
      cnt_q        <= '0;
      steps_q      <= '0;
      div_resetn_q <= 1'b0;
      div_calib_q  <= 1'b0;
      lcd_rst_q    <= 1'b1;
      ready_q      <= 1'b0;
      busy_q       <= 1'b0;
      calib_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      steps_q      <= steps_d;
      div_resetn_q <= div_resetn_d;
      div_calib_q  <= div_calib_d;
      lcd_rst_q    <= lcd_rst_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
      calib_done_q <= calib_done_d;
    end
  end

  assign div_resetn = div_resetn_q;
  assign div_calib  = div_calib_q;
  assign lcd_rst    = lcd_rst_q;
  assign ready      = ready_q;
  assign busy       = busy_q;
  assign calib_done = calib_done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_lcd_clkdiv_ctrl.sv
// Bench for lcd_clkdiv_ctrl: per-cycle scoreboard against a lock-run-length /
// calibration-timeline model, a calibration table, and directed corner sequences.
module tb_lcd_clkdiv_ctrl;
  import lcd_clk_pkg::*;

  localparam int L  = 16;
  localparam int S  = 8;
  localparam int H  = 4;
  localparam int G  = 8;
  localparam int SW = 4;
  localparam int P  = H + G;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pll_lock = 1'b0;
  logic calib_req = 1'b0;
  logic [SW-1:0] calib_steps = '0;
  logic div_resetn, div_calib, lcd_rst, ready, busy, calib_done;
  lcd_state_e dbg_state;

  // clock / reset block
  always #5 clk = ~clk;

  lcd_clkdiv_ctrl #(
    .LOCK_CYCLES   (L),
    .SETTLE_CYCLES (S),
    .CALIB_HIGH    (H),
    .CALIB_GAP     (G),
    .STEP_W        (SW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pll_lock    (pll_lock),
    .calib_req   (calib_req),
    .calib_steps (calib_steps),
    .div_resetn  (div_resetn),
    .div_calib   (div_calib),
    .lcd_rst     (lcd_rst),
    .ready       (ready),
    .busy        (busy),
    .calib_done  (calib_done),
    .dbg_state   (dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  logic [5:0] exp_q[$];

  // Reference: consecutive qualified-lock cycles and position in the calibration train.
  int m_run = 0;
  int m_cal_len = 0;
  int m_cal_pos = 0;
  bit m_done = 1'b0;
  bit [1:0] m_hist = 2'b00;

  function automatic logic [5:0] model_out();
    logic cal_on;
    cal_on = (m_cal_len != 0);
    return {m_run >= L, cal_on && ((m_cal_pos % P) < H), m_run < L + S,
            (m_run >= L + S) && !cal_on, cal_on, m_done};
  endfunction

  task automatic model_step();
    bit lk;
    bit was_ready;
    if (reset) begin
      m_run = 0; m_cal_len = 0; m_cal_pos = 0; m_done = 1'b0; m_hist = 2'b00;
    end else begin
      lk = m_hist[1];
      was_ready = (m_run >= L + S) && (m_cal_len == 0);
      m_done = 1'b0;
      if (!lk) begin
        m_run = 0; m_cal_len = 0; m_cal_pos = 0;
      end else begin
        if (m_cal_len != 0) begin
          m_cal_pos++;
          if (m_cal_pos == m_cal_len) begin
            m_cal_len = 0; m_cal_pos = 0; m_done = 1'b1;
          end
        end else if (was_ready && calib_req) begin
          if (calib_steps == 0) m_done = 1'b1;
          else begin
            m_cal_len = int'(calib_steps) * P; m_cal_pos = 0;
          end
        end
        if (m_run < L + S) m_run++;
      end
      m_hist = {m_hist[0], pll_lock};
    end
    exp_q.push_back(model_out());
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic logic [5:0] outs();
    return {div_resetn, div_calib, lcd_rst, ready, busy, calib_done};
  endfunction

  // driver: one clock with scoreboard check just after the edge
  task automatic cycle();
    logic [5:0] e;
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    e = exp_q.pop_front();
    n_cmp++;
    if (outs() !== e) begin
      n_err++;
      $display("FAIL outputs @cycle %0d: got %b expected %b {resetn,calib,lcd_rst,ready,busy,done}",
               cyc, outs(), e);
    end
  endtask

  task automatic wait_div_resetn(input string name);
    int k;
    k = 0;
    do begin cycle(); k++; end while (!div_resetn && k < 100);
    check(name, k, L + 2);
  endtask

  task automatic wait_ready(input string name);
    int k;
    k = 0;
    do begin cycle(); k++; end while (!ready && k < 100);
    check(name, k, S);
    check({name, "_lcd_rst"}, int'(lcd_rst), 0);
  endtask

  typedef struct {
    int steps;
    int busy_cyc;
    int pulses;
    int high_cyc;
    int done_cnt;
  } cal_vec_t;

  cal_vec_t tbl[4];

  initial begin
    int drop;
    bit any_calib;
    tbl[0] = '{3, 36, 3, 12, 1};
    tbl[1] = '{0, 0, 0, 0, 1};
    tbl[2] = '{1, 12, 1, 4, 1};
    tbl[3] = '{15, 180, 15, 60, 1};

    // Power-up
    repeat (4) cycle();
    check("reset_outputs", int'(outs()), int'(6'b001000));
    check("reset_state", int'(dbg_state), int'(WAIT_LOCK));
    reset = 1'b0;
    cycle();
    pll_lock = 1'b1;
    any_calib = 1'b0;
    wait_div_resetn("powerup_div_resetn");
    wait_ready("powerup_ready");
    check("powerup_no_calib", int'(any_calib | div_calib), 0);

    // Lock glitch after 10 qualified cycles
    reset = 1'b1;
    repeat (2) cycle();
    reset = 1'b0;
    repeat (12) cycle();
    check("glitch_pre_resetn", int'(div_resetn), 0);
    pll_lock = 1'b0;
    cycle();
    pll_lock = 1'b1;
    wait_div_resetn("glitch_div_resetn");

    // Requests throughout SETTLE, including the RUN-entry cycle, are dropped
    calib_req = 1'b1;
    calib_steps = 4'd3;
    repeat (S) cycle();
    calib_req = 1'b0;
    repeat (2) cycle();
    check("settle_req_busy", int'(busy), 0);
    check("settle_req_ready", int'(ready), 1);

    // Calibration table
    for (int i = 0; i < 4; i++) begin
      int bc, pc, hc, dc;
      logic prev;
      bc = 0; pc = 0; hc = 0; dc = 0; prev = 1'b0;
      for (int c = 0; c < tbl[i].busy_cyc + 4; c++) begin
        calib_req = (c == 0);
        calib_steps = (c == 0) ? SW'(tbl[i].steps) : SW'($urandom_range(0, 15));
        cycle();
        bc += int'(busy);
        hc += int'(div_calib);
        dc += int'(calib_done);
        if (div_calib && !prev) pc++;
        prev = div_calib;
      end
      check($sformatf("tbl%0d_busy", i), bc, tbl[i].busy_cyc);
      check($sformatf("tbl%0d_pulses", i), pc, tbl[i].pulses);
      check($sformatf("tbl%0d_high", i), hc, tbl[i].high_cyc);
      check($sformatf("tbl%0d_done", i), dc, tbl[i].done_cnt);
      check($sformatf("tbl%0d_ready", i), int'(ready), 1);
    end

    // Lock loss during the second CALIB pulse
    calib_req = 1'b1;
    calib_steps = 4'd3;
    cycle();
    calib_req = 1'b0;
    repeat (13) cycle();
    check("loss_second_pulse", int'(div_calib), 1);
    pll_lock = 1'b0;
    repeat (3) cycle();
    check("loss_outputs", int'(outs()), int'(6'b001000));
    check("loss_state", int'(dbg_state), int'(WAIT_LOCK));
    begin
      int dc;
      dc = 0;
      repeat (5) begin cycle(); dc += int'(calib_done); end
      check("loss_no_done", dc, 0);
    end
    pll_lock = 1'b1;
    wait_div_resetn("relock_div_resetn");
    wait_ready("relock_ready");

    // Reset in the middle of a CALIB train
    calib_req = 1'b1;
    calib_steps = 4'd2;
    cycle();
    calib_req = 1'b0;
    repeat (5) cycle();
    check("midcal_busy", int'(busy), 1);
    reset = 1'b1;
    cycle();
    check("midcal_reset_outputs", int'(outs()), int'(6'b001000));
    check("midcal_reset_state", int'(dbg_state), int'(WAIT_LOCK));
    reset = 1'b0;

    // Randomized traffic: requests, lock drops, occasional reset
    drop = 0;
    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 699) == 0);
      if (drop == 0 && $urandom_range(0, 299) == 0) drop = $urandom_range(1, 3);
      pll_lock = (drop == 0);
      if (drop > 0) drop--;
      calib_req = ($urandom_range(0, 7) == 0);
      calib_steps = SW'($urandom_range(0, 3));
      cycle();
    end
    reset = 1'b0;
    pll_lock = 1'b1;
    calib_req = 1'b0;
    repeat (60) cycle();
    check("final_ready", int'(ready), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lcd_clkdiv_ctrl.md
Name: lcd_clkdiv_ctrl

Overview:
- Sequences the LCD pixel-clock divider (Gowin CLKDIV, DIV_MODE 3.5).
- Waits for a stable PLL lock, then releases the divider reset, waits for the divider output to settle, and releases the LCD-domain reset.
- Afterwards, issues counted CALIB pulse trains on request, so the pixel clock phase can be trimmed without re-locking.
- Runs in a free-running system clock domain, alongside the divider instance in the LCD clocking top level.

Parameters:
- LOCK_CYCLES, 1024: consecutive synchronised-lock cycles required before the divider reset is released.
- SETTLE_CYCLES, 64: cycles between divider reset release and lcd_rst deassertion.
- CALIB_HIGH, 4: width of each div_calib pulse, in clk cycles (must be ≥1).
- CALIB_GAP, 8: low time after each div_calib pulse, in clk cycles (must be ≥1).
- STEP_W, 4: width of the calibration step-count input.

Ports:
- clk  in  1  system clock, free-running, independent of the divider input clock.
- reset  in  1  synchronous, active-high.
- pll_lock  in  1  PLL lock, asynchronous; double-flop synchronised internally.
- calib_req  in  1  single-cycle request to start a calibration train.
- calib_steps  in  STEP_W  number of CALIB pulses; sampled when calib_req is accepted.
- div_resetn  out  1  drives the CLKDIV RESETN input.
- div_calib  out  1  drives the CLKDIV CALIB input.
- lcd_rst  out  1  active-high reset for LCD-domain logic (to be synchronised in that domain).
- ready  out  1  high in state RUN only.
- busy  out  1  high in state CALIB.
- calib_done  out  1  one-cycle pulse when a calibration train completes.

Behaviour:
- Reset values: div_resetn=0, div_calib=0, lcd_rst=1, ready=0, busy=0, calib_done=0. State = WAIT_LOCK, all counters 0. The lock synchroniser flops clear to 0.
- lk denotes the synchronised lock (2-flop). A raw pll_lock edge reaches lk after 2 clk cycles.
- All outputs are registered.
- States:
  - WAIT_LOCK: counter increments while lk=1 and clears when lk=0. When the counter reaches LOCK_CYCLES-1 with lk=1, go to SETTLE and set div_resetn=1 on that transition.
  - SETTLE: counter counts SETTLE_CYCLES cycles. On the final cycle go to RUN; lcd_rst=0 and ready=1 from the first RUN cycle.
  - RUN: calib_req=1 latches calib_steps.
    - If the latched value is 0: calib_done pulses on the next cycle and the state stays RUN.
    - Otherwise: go to CALIB, busy=1, ready=0.
  - CALIB: repeat for each step: div_calib=1 for CALIB_HIGH cycles, then 0 for CALIB_GAP cycles.
    - After the last gap: return to RUN, calib_done=1 for one cycle, busy=0, ready=1.
    - Total duration = steps*(CALIB_HIGH+CALIB_GAP) cycles.
- lcd_rst stays 0 throughout CALIB.
- calib_req outside RUN is ignored, with no queuing. This includes a request in the same cycle the state enters RUN from SETTLE.
- Lock loss: lk=0 in SETTLE, RUN or CALIB causes the next cycle to be WAIT_LOCK with:
  - div_resetn=0, div_calib=0, lcd_rst=1, ready=0, busy=0;
  - no calib_done;
  - counters cleared.
- A lock glitch shorter than LOCK_CYCLES in WAIT_LOCK restarts the count from 0.
- reset asserted in any state returns to the reset values on the next edge, overriding any lock activity.
- Counters are sized with $clog2 of the maximum of LOCK_CYCLES, SETTLE_CYCLES, CALIB_HIGH and CALIB_GAP. The step counter is STEP_W bits and counts down to 0, so it never wraps.

Decomposition:
- Shared package lcd_clk_pkg holds:
  - the state enum (WAIT_LOCK, SETTLE, RUN, CALIB);
  - default constants for LOCK_CYCLES, SETTLE_CYCLES, CALIB_HIGH and CALIB_GAP.
- One sub-module, lcd_sync2: a 2-flop synchroniser for pll_lock, reset value 0, reused by other clock-domain-crossing inputs in the codebase.
- The controller drives the existing divider instance directly; no divider logic lives in this block.

Test Plan:
- Power-up: reset for 4 cycles, then pll_lock=1 permanently (LOCK_CYCLES=16, SETTLE_CYCLES=8).
  - div_resetn rises exactly 2+16 cycles after pll_lock rises.
  - lcd_rst falls and ready rises 8 cycles after that.
  - div_calib stays 0 throughout.
- Lock glitch: pll_lock drops for 1 cycle after 10 locked cycles in WAIT_LOCK -> the count restarts, and div_resetn rises 16 cycles after lk returns high.
- Calibration with calib_steps=3 (CALIB_HIGH=4, CALIB_GAP=8):
  - exactly 3 div_calib pulses, each 4 cycles high, separated by 8 low cycles;
  - busy=1 for 36 cycles;
  - calib_done pulses once, then ready=1.
- calib_steps=0 in RUN -> calib_done one cycle later, no div_calib pulse, busy stays 0. calib_req during SETTLE -> ignored.
- Lock loss during the second CALIB pulse -> next cycle div_calib=0, div_resetn=0, lcd_rst=1, no calib_done. After relock, the full WAIT_LOCK/SETTLE sequence repeats.
- reset asserted mid-CALIB -> all outputs return to reset values on the next edge, state = WAIT_LOCK.
